// File: rtl/systolic_skew_feeder_if.sv
// Operand stream into the systolic skew feeder: one unskewed A column and
// B row per beat, qualified by a valid/ready handshake and a last marker.
interface systolic_skew_feeder_if #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16
);
    logic [ARR_SIZE*HORIZONTAL_BW-1:0] a_vec;
    logic [ARR_SIZE*HORIZONTAL_BW-1:0] b_vec;
    logic                              in_valid;
    logic                              in_last;
    logic                              in_ready;

    modport master (output a_vec, b_vec, in_valid, in_last, input in_ready);
    modport slave  (input a_vec, b_vec, in_valid, in_last, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skew feeder for an ARR_SIZE x ARR_SIZE systolic MAC array.
// Lane i of each operand bus is delayed by i cycles, so the array sees a
// diagonal wavefront. After the last beat, zeros are flushed until the final
// operand pair reaches the bottom-right PE, and then done pulses.
// Optional: define FEEDER_STALL_CNT_EN to add the stall_cnt port and counter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for the first beat of a job; zeros are injected
// S_STREAM | accepting beats; each bubble cycle injects a zero wavefront
// S_FLUSH  | injecting zeros while the last wavefront drains diagonally
// S_DONE   | one-cycle done pulse; zeros are injected
module systolic_skew_feeder #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16,
    parameter int CNT_W         = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    systolic_skew_feeder_if.slave             feed,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] horizontal_out,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] vertical_out,
    output logic                              o_mode,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_W-1:0]                  beat_cnt
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int BW      = HORIZONTAL_BW;
    localparam int FLUSH_W = $clog2(2 * ARR_SIZE);
    localparam logic [FLUSH_W-1:0] FLUSH_LEN = FLUSH_W'(2 * ARR_SIZE - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       in_ready;
    logic                       accept;
    logic [FLUSH_W-1:0]         flush_cnt;
    logic [ARR_SIZE*BW-1:0]     inj_a;
    logic [ARR_SIZE*BW-1:0]     inj_b;

    assign feed.in_ready = in_ready;
    assign accept        = feed.in_valid && in_ready;

    // Only accepted beats enter the skew chain; every other cycle injects zeros.
    assign inj_a = accept ? feed.a_vec : '0;
    assign inj_b = accept ? feed.b_vec : '0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        o_mode    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (feed.in_valid) state_nxt = feed.in_last ? S_FLUSH : S_STREAM;
            end
            S_STREAM: begin
                in_ready = 1'b1;
                o_mode   = 1'b1;
                if (feed.in_valid && feed.in_last) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                o_mode = 1'b1;
                if (flush_cnt == FLUSH_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Flush length: the last wavefront needs 2*ARR_SIZE-2 more cycles to reach
    // the bottom-right PE before done can be flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flush_cnt <= '0;
        else if (state_nxt == S_FLUSH && state != S_FLUSH)
            flush_cnt <= FLUSH_LEN;
        else if (state == S_FLUSH)
            flush_cnt <= flush_cnt - FLUSH_W'(1);
    end

    // Beat counter: restarts at 1 on the first beat of a job and saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            beat_cnt <= '0;
        else if (accept) begin
            if (state == S_IDLE)
                beat_cnt <= CNT_W'(1);
            else if (beat_cnt != '1)
                beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    // Bubble counter: STREAM cycles without an offered beat; wraps freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (accept && state == S_IDLE)
            stall_cnt <= '0;
        else if (state == S_STREAM && !feed.in_valid)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

    // Per-lane skew: lane i has i delay stages followed by the output register.
    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
        logic [BW-1:0] h_q;
        logic [BW-1:0] v_q;

        assign horizontal_out[i*BW +: BW] = h_q;
        assign vertical_out[i*BW +: BW]   = v_q;

        if (i == 0) begin : g_direct
            // Lane 0 registers the injected operand directly.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    h_q <= '0;
                    v_q <= '0;
                end else begin
                    h_q <= inj_a[BW-1:0];
                    v_q <= inj_b[BW-1:0];
                end
            end
        end else begin : g_delayed
            logic [BW-1:0] a_dly [i];
            logic [BW-1:0] b_dly [i];

            // Shift the lane through its delay stages, then into the output register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_dly[s] <= '0;
                        b_dly[s] <= '0;
                    end
                    h_q <= '0;
                    v_q <= '0;
                end else begin
                    a_dly[0] <= inj_a[i*BW +: BW];
                    b_dly[0] <= inj_b[i*BW +: BW];
                    for (int s = 1; s < i; s++) begin
                        a_dly[s] <= a_dly[s-1];
                        b_dly[s] <= b_dly[s-1];
                    end
                    h_q <= a_dly[i-1];
                    v_q <= b_dly[i-1];
                end
            end
        end
    end

endmodule
